// File: rtl/fb_pkg.sv
// fb_pkg: framebuffer geometry, widths, clear-FSM states
// and the linear address helper shared by the arbiter slice.
package fb_pkg;

  localparam int FB_W        = 200;
  localparam int FB_H        = 150;
  localparam int SCALE_SHIFT = 2;
  localparam int ADDR_W      = 15;
  localparam int COLOR_W     = 12;
  localparam int FB_WORDS    = FB_W * FB_H;

  typedef enum logic {
    CLR_IDLE = 1'b0,
    CLR_BUSY = 1'b1
  } clr_state_t;

  function automatic logic [ADDR_W-1:0] fb_addr(
    input logic [ADDR_W-1:0] x,
    input logic [ADDR_W-1:0] y
  );
    return y * ADDR_W'(FB_W) + x;
  endfunction

endpackage

// File: rtl/fb_scan_arbiter_if.sv
// fb_scan_arbiter_if: two valid/ready pixel writers.
// master = game-logic side, slave = arbiter side.
interface fb_scan_arbiter_if;
  import fb_pkg::*;

  logic               wr0_valid;
  logic               wr0_ready;
  logic [7:0]         wr0_x;
  logic [7:0]         wr0_y;
  logic [COLOR_W-1:0] wr0_data;

  logic               wr1_valid;
  logic               wr1_ready;
  logic [7:0]         wr1_x;
  logic [7:0]         wr1_y;
  logic [COLOR_W-1:0] wr1_data;

  modport master (
    output wr0_valid, wr0_x, wr0_y, wr0_data,
    output wr1_valid, wr1_x, wr1_y, wr1_data,
    input  wr0_ready, wr1_ready
  );

  modport slave (
    input  wr0_valid, wr0_x, wr0_y, wr0_data,
    input  wr1_valid, wr1_x, wr1_y, wr1_data,
    output wr0_ready, wr1_ready
  );

endinterface

// File: rtl/fb_rr_arbiter.sv
// fb_rr_arbiter: 2-way round-robin grant in free slots.
// Ports: clk, rst_n, req[1:0], slot_free -> gnt[1:0].
module fb_rr_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       slot_free,
  output logic [1:0] gnt
);

  // last writer granted; reset to 1 so wr0 wins
  // the first tie
  logic last;

  always_comb begin
    gnt = 2'b00;
    if (slot_free) begin
      unique case (1'b1)
        (req == 2'b11): gnt = last ? 2'b01 : 2'b10;
        (req == 2'b01): gnt = 2'b01;
        (req == 2'b10): gnt = 2'b10;
        default:        gnt = 2'b00;
      endcase
    end
  end

  // a grant is a transfer: ready == gnt, valid held
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= 1'b1;
    end else if (gnt[0]) begin
      last <= 1'b0;
    end else if (gnt[1]) begin
      last <= 1'b1;
    end
  end

endmodule

// File: rtl/fb_scan_arbiter.sv
// fb_scan_arbiter: single-port framebuffer shared by 4x scan-out
// and two writers; optional clear engine under FB_CLEAR_EN.
module fb_scan_arbiter
  import fb_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic [9:0]         pixel_x,
  input  logic [9:0]         pixel_y,
  output logic [3:0]         fb_r,
  output logic [3:0]         fb_g,
  output logic [3:0]         fb_b,
  fb_scan_arbiter_if.slave   wr,
  input  logic               clear_start,
  input  logic [COLOR_W-1:0] clear_color,
  output logic               clear_busy,
  output logic               ram_en,
  output logic               ram_we,
  output logic [ADDR_W-1:0]  ram_addr,
  output logic [COLOR_W-1:0] ram_wdata,
  input  logic [COLOR_W-1:0] ram_rdata
);

  localparam logic [9:0] BLANK = 10'h3FF;
  localparam logic [9:0] W10   = 10'(FB_W);
  localparam logic [9:0] H10   = 10'(FB_H);
  localparam logic [7:0] W8    = 8'(FB_W);
  localparam logic [7:0] H8    = 8'(FB_H);

  logic [9:0] fx;
  logic [9:0] fy;
  logic       vis;
  logic       disp;

  assign fx   = pixel_x >> SCALE_SHIFT;
  assign fy   = pixel_y >> SCALE_SHIFT;
  assign vis  = (pixel_x != BLANK) && (pixel_y != BLANK)
              && (fx < W10) && (fy < H10);
  assign disp = reset_n && vis
              && (pixel_x[SCALE_SHIFT-1:0] == '0);

  // stage 1 remembers what the slot at T was,
  // stage 2 acts on it when ram_rdata is valid
  logic               s1_load;
  logic               s1_zero;
  logic [COLOR_W-1:0] pix_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_load <= 1'b0;
      s1_zero <= 1'b1;
      pix_q   <= '0;
    end else begin
      s1_load <= disp;
      s1_zero <= !vis;
      if (s1_load) begin
        pix_q <= ram_rdata;
      end else if (s1_zero) begin
        pix_q <= '0;
      end
    end
  end

  assign fb_r = pix_q[11:8];
  assign fb_g = pix_q[7:4];
  assign fb_b = pix_q[3:0];

  logic               clr_wr;
  logic [ADDR_W-1:0]  clr_cnt;
  logic [COLOR_W-1:0] clr_col;

`ifdef FB_CLEAR_EN
  clr_state_t st;

  assign clr_wr     = (st == CLR_BUSY) && !disp;
  assign clear_busy = (st == CLR_BUSY);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st      <= CLR_IDLE;
      clr_cnt <= '0;
      clr_col <= '0;
    end else begin
      unique case (st)
        CLR_IDLE: begin
          if (clear_start) begin
            st      <= CLR_BUSY;
            clr_cnt <= '0;
            clr_col <= clear_color;
          end
        end
        CLR_BUSY: begin
          if (clr_wr) begin
            clr_cnt <= clr_cnt + 1'b1;
            if (clr_cnt == ADDR_W'(FB_WORDS - 1)) begin
              st <= CLR_IDLE;
            end
          end
        end
        default: st <= CLR_IDLE;
      endcase
    end
  end
`else
  logic unused_clr;

  assign unused_clr = ^{clear_start, clear_color};
  assign clr_wr     = 1'b0;
  assign clr_cnt    = '0;
  assign clr_col    = '0;
  assign clear_busy = 1'b0;
`endif

  logic       slot_free;
  logic [1:0] gnt;

  assign slot_free = reset_n && !disp && !clear_busy;

  fb_rr_arbiter u_rr (
    .clk       (clk),
    .rst_n     (reset_n),
    .req       ({wr.wr1_valid, wr.wr0_valid}),
    .slot_free (slot_free),
    .gnt       (gnt)
  );

  assign wr.wr0_ready = gnt[0];
  assign wr.wr1_ready = gnt[1];

  logic [7:0]         wx;
  logic [7:0]         wy;
  logic [COLOR_W-1:0] wd;
  logic               w_hit;

  assign wx    = gnt[1] ? wr.wr1_x    : wr.wr0_x;
  assign wy    = gnt[1] ? wr.wr1_y    : wr.wr0_y;
  assign wd    = gnt[1] ? wr.wr1_data : wr.wr0_data;
  // off-buffer writes are accepted but dropped
  assign w_hit = (|gnt) && (wx < W8) && (wy < H8);

  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    unique case (1'b1)
      disp: begin
        ram_en   = 1'b1;
        ram_addr = fb_addr(ADDR_W'(fx), ADDR_W'(fy));
      end
      clr_wr: begin
        ram_en    = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = clr_cnt;
        ram_wdata = clr_col;
      end
      w_hit: begin
        ram_en    = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = fb_addr(ADDR_W'(wx), ADDR_W'(wy));
        ram_wdata = wd;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fb_scan_arbiter.sv
// tb_fb_scan_arbiter: directed vectors against a sync-read
// RAM model; clear vectors only when FB_CLEAR_EN is defined.
module tb_fb_scan_arbiter;
  import fb_pkg::*;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic [9:0]         pixel_x;
  logic [9:0]         pixel_y;
  logic [3:0]         fb_r, fb_g, fb_b;
  logic               clear_start;
  logic [COLOR_W-1:0] clear_color;
  logic               clear_busy;
  logic               ram_en, ram_we;
  logic [ADDR_W-1:0]  ram_addr;
  logic [COLOR_W-1:0] ram_wdata;
  logic [COLOR_W-1:0] ram_rdata;
  logic [11:0]        fbc;

  logic               ld_en;
  logic [ADDR_W-1:0]  ld_addr;
  logic [COLOR_W-1:0] ld_data;
  logic [COLOR_W-1:0] mem [0:FB_WORDS-1];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fb_scan_arbiter_if wif ();

  fb_scan_arbiter dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
    .fb_r        (fb_r),
    .fb_g        (fb_g),
    .fb_b        (fb_b),
    .wr          (wif),
    .clear_start (clear_start),
    .clear_color (clear_color),
    .clear_busy  (clear_busy),
    .ram_en      (ram_en),
    .ram_we      (ram_we),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata)
  );

  assign fbc = {fb_r, fb_g, fb_b};

  always @(posedge clk) begin
    if (ld_en) begin
      mem[ld_addr] <= ld_data;
    end else if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else ram_rdata <= mem[ram_addr];
    end
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h",
               tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic load(
    input logic [ADDR_W-1:0]  a,
    input logic [COLOR_W-1:0] d
  );
    ld_en   = 1'b1;
    ld_addr = a;
    ld_data = d;
    nxt();
    ld_en   = 1'b0;
  endtask

  initial begin
    int bad_w;
    int bad_h;
    logic [11:0] exp_c;

    pixel_x        = 10'h3FF;
    pixel_y        = 10'h3FF;
    clear_start    = 1'b0;
    clear_color    = '0;
    ld_en          = 1'b0;
    ld_addr        = '0;
    ld_data        = '0;
    wif.wr0_valid  = 1'b0;
    wif.wr0_x      = '0;
    wif.wr0_y      = '0;
    wif.wr0_data   = '0;
    wif.wr1_valid  = 1'b0;
    wif.wr1_x      = '0;
    wif.wr1_y      = '0;
    wif.wr1_data   = '0;

    // reset state, RAM preload
    nxt();
    load(15'd0, 12'hF00);
    load(15'd1, 12'h0F0);
    load(15'd2, 12'h123);
    wif.wr0_valid = 1'b1;
    #2;
    chk("rst_fb",   32'(fbc), 32'h0);
    chk("rst_busy", 32'(clear_busy), 32'h0);
    chk("rst_rdy",  32'(wif.wr0_ready), 32'h0);
    chk("rst_en",   32'(ram_en), 32'h0);
    wif.wr0_valid = 1'b0;
    nxt();
    reset_n = 1'b1;
    nxt();
    nxt();

    // raster x=0..9 on line 0
    for (int k = 0; k < 10; k++) begin
      pixel_x = 10'(k);
      pixel_y = 10'd0;
      #2;
      if (k % 4 == 0) begin
        chk("rd_en",   32'(ram_en), 32'h1);
        chk("rd_we",   32'(ram_we), 32'h0);
        chk("rd_addr", 32'(ram_addr), 32'(k / 4));
      end else begin
        chk("rd_idle", 32'(ram_en), 32'h0);
      end
      if (k < 2) exp_c = 12'h000;
      else if (k < 6) exp_c = 12'hF00;
      else exp_c = 12'h0F0;
      chk("rd_fb", 32'(fbc), 32'(exp_c));
      nxt();
    end

    // blanking zeroes output two cycles later
    pixel_x = 10'h3FF;
    #2;
    chk("blk_en",  32'(ram_en), 32'h0);
    chk("blk_fb0", 32'(fbc), 32'h123);
    nxt();
    #2;
    chk("blk_fb1", 32'(fbc), 32'h123);
    nxt();
    #2;
    chk("blk_fb2", 32'(fbc), 32'h0);
    nxt();

    // two writers in blanking alternate
    wif.wr0_x     = 8'd1;
    wif.wr0_y     = 8'd0;
    wif.wr0_data  = 12'hA0A;
    wif.wr1_x     = 8'd10;
    wif.wr1_y     = 8'd3;
    wif.wr1_data  = 12'h5B5;
    wif.wr0_valid = 1'b1;
    wif.wr1_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #2;
      chk("rr_rdy0", 32'(wif.wr0_ready),
          32'(i % 2 == 0));
      chk("rr_rdy1", 32'(wif.wr1_ready),
          32'(i % 2 == 1));
      chk("rr_we",   32'(ram_we), 32'h1);
      chk("rr_addr", 32'(ram_addr),
          (i % 2 == 0) ? 32'd1 : 32'd610);
      chk("rr_data", 32'(ram_wdata),
          (i % 2 == 0) ? 32'hA0A : 32'h5B5);
      nxt();
    end
    wif.wr1_valid = 1'b0;

    // single writer inside an active line
    wif.wr0_x    = 8'd5;
    wif.wr0_y    = 8'd2;
    wif.wr0_data = 12'h3C3;
    for (int k = 0; k < 8; k++) begin
      pixel_x = 10'(k);
      pixel_y = 10'd0;
      #2;
      chk("act_rdy", 32'(wif.wr0_ready),
          32'(k % 4 != 0));
      chk("act_addr", 32'(ram_addr),
          (k % 4 != 0) ? 32'd405 : 32'(k / 4));
      nxt();
    end

    // raster edges: x=800, y=600 are off-buffer
    pixel_x = 10'd800;
    #2;
    chk("x800_rdy", 32'(wif.wr0_ready), 32'h1);
    chk("x800_adr", 32'(ram_addr), 32'd405);
    nxt();
    pixel_x = 10'd0;
    pixel_y = 10'd600;
    #2;
    chk("y600_rdy", 32'(wif.wr0_ready), 32'h1);
    nxt();
    pixel_x = 10'd796;
    pixel_y = 10'd596;
    #2;
    chk("x796_rdy", 32'(wif.wr0_ready), 32'h0);
    chk("x796_adr", 32'(ram_addr), 32'd29999);
    nxt();
    wif.wr0_valid = 1'b0;
    pixel_x = 10'h3FF;
    pixel_y = 10'h3FF;

    // off-buffer writes accepted, not written
    wif.wr1_x     = 8'd200;
    wif.wr1_y     = 8'd0;
    wif.wr1_valid = 1'b1;
    #2;
    chk("oob_x_rdy", 32'(wif.wr1_ready), 32'h1);
    chk("oob_x_en",  32'(ram_en), 32'h0);
    nxt();
    wif.wr1_x = 8'd0;
    wif.wr1_y = 8'd150;
    #2;
    chk("oob_y_rdy", 32'(wif.wr1_ready), 32'h1);
    chk("oob_y_en",  32'(ram_en), 32'h0);
    nxt();
    wif.wr1_valid = 1'b0;

`ifdef FB_CLEAR_EN
    // full clear; writer in start cycle completes
    clear_start   = 1'b1;
    clear_color   = 12'h00F;
    wif.wr0_x     = 8'd7;
    wif.wr0_y     = 8'd0;
    wif.wr0_data  = 12'h777;
    wif.wr0_valid = 1'b1;
    #2;
    chk("cs_rdy",  32'(wif.wr0_ready), 32'h1);
    chk("cs_addr", 32'(ram_addr), 32'd7);
    nxt();
    clear_start = 1'b0;
    bad_w = 0;
    bad_h = 0;
    for (int i = 0; i < FB_WORDS; i++) begin
      clear_start = (i == 100);
      clear_color = (i == 100) ? 12'hFFF : 12'h00F;
      #2;
      if (!ram_en || !ram_we
          || ram_addr != ADDR_W'(i)
          || ram_wdata != 12'h00F) bad_w++;
      if (!clear_busy || wif.wr0_ready
          || wif.wr1_ready) bad_h++;
      nxt();
    end
    clear_start = 1'b0;
    chk("clr_writes", 32'(bad_w), 32'h0);
    chk("clr_hshake", 32'(bad_h), 32'h0);
    wif.wr0_valid = 1'b0;
    #2;
    chk("clr_done",  32'(clear_busy), 32'h0);
    chk("clr_w0",    32'(mem[0]), 32'h00F);
    chk("clr_w7",    32'(mem[7]), 32'h00F);
    chk("clr_wlast", 32'(mem[FB_WORDS-1]),
        32'h00F);
    nxt();
    exp_c = 12'h00F;
`else
    exp_c = 12'hF00;
`endif

    // reset while busy / with live colour
    pixel_x = 10'd0;
    pixel_y = 10'd0;
    nxt();
    pixel_x = 10'd1;
    nxt();
    nxt();
    #2;
    chk("pre_rst_fb", 32'(fbc), 32'(exp_c));
`ifdef FB_CLEAR_EN
    clear_start = 1'b1;
    clear_color = 12'h0F0;
    nxt();
    clear_start = 1'b0;
    repeat (50) nxt();
    #2;
    chk("mid_busy", 32'(clear_busy), 32'h1);
`endif
    #1;
    reset_n = 1'b0;
    #1;
    chk("arst_busy", 32'(clear_busy), 32'h0);
    chk("arst_fb",   32'(fbc), 32'h0);
    chk("arst_en",   32'(ram_en), 32'h0);
    nxt();
    nxt();
    reset_n = 1'b1;
    pixel_x = 10'h3FF;
    pixel_y = 10'h3FF;
    nxt();
    #2;
    chk("post_busy", 32'(clear_busy), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
